// File: rtl/fpaddsub_normalize_pipe.sv
// fpaddsub_normalize_pipe: 3-stage leading-zero normalizer; FPADDSUB_NORM_EXP_EN adds exponent adjust/underflow
module fpaddsub_normalize_pipe #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  localparam int SHIFT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_mant,
  output logic [SHIFT_W-1:0] out_shift,
`ifdef FPADDSUB_NORM_EXP_EN
  input  logic [EXP_W-1:0]   in_exp,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_uflow,
`endif
  output logic               out_zero
);
  logic adv, v1, v2, v3, z1, z2, z3;
  logic [WIDTH-1:0] m1, m2, m3;
  logic [SHIFT_W-1:0] lzc, l1, l2, l3;
  assign adv = !v3 || out_ready;
  assign in_ready = rst_n && adv && !flush;
  always_comb begin
    lzc = SHIFT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) lzc = in_mant[i] ? SHIFT_W'(WIDTH - 1 - i) : lzc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v1, v2, v3} <= '0;
    else if (flush) {v1, v2, v3} <= '0;
    else if (adv) {v1, v2, v3} <= {in_valid, v1, v2};
  always_ff @(posedge clk)
    if (adv) begin
      m1 <= in_mant;
      l1 <= lzc;
      z1 <= ~|in_mant;
      m2 <= m1 << {l1[SHIFT_W-1:2], 2'b00};
      l2 <= l1;
      z2 <= z1;
      m3 <= m2 << l2[1:0];
      l3 <= l2;
      z3 <= z2;
    end
  assign out_valid = v3;
  assign out_mant  = v3 ? m3 : '0;
  assign out_shift = v3 ? l3 : '0;
  assign out_zero  = v3 && z3;
`ifdef FPADDSUB_NORM_EXP_EN
  localparam int CW = EXP_W + SHIFT_W;
  logic [EXP_W-1:0] e1, e2, e3, en;
  logic [CW-1:0] ce, cs;
  logic uf, u3;
  assign ce = CW'(e2);
  assign cs = CW'(l2);
  assign uf = !z2 && (cs > ce);
  assign en = (z2 || uf) ? '0 : EXP_W'(ce - cs);
  always_ff @(posedge clk)
    if (adv) begin
      e1 <= in_exp;
      e2 <= e1;
      e3 <= en;
      u3 <= uf;
    end
  assign out_exp   = v3 ? e3 : '0;
  assign out_uflow = v3 && u3;
`endif
endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// tb_fpaddsub_normalize_pipe: directed + random checks against a 3-slot pipeline reference model
module tb_fpaddsub_normalize_pipe;
  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_mant, out_mant;
  logic [5:0] out_shift;
`ifdef FPADDSUB_NORM_EXP_EN
  logic [7:0] in_exp, out_exp;
  logic out_uflow;
`endif
  int checks = 0;
  int errors = 0;
  logic mv[3];
  logic [31:0] mm[3];
  logic [7:0] me[3];
  logic [31:0] words[4];
  fpaddsub_normalize_pipe #(.WIDTH(32), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_shift(out_shift),
`ifdef FPADDSUB_NORM_EXP_EN
    .in_exp(in_exp), .out_exp(out_exp), .out_uflow(out_uflow),
`endif
    .out_zero(out_zero)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int lz(input logic [31:0] m);
    return 32 - $clog2({32'd0, m} + 64'd1);
  endfunction
  task automatic check_out();
    int l;
    l = lz(mm[2]);
    chk("out_mant", out_mant, 64'(32'({32'd0, mm[2]} << l)));
    chk("out_shift", out_shift, l);
    chk("out_zero", out_zero, mm[2] == 0);
`ifdef FPADDSUB_NORM_EXP_EN
    begin
      logic uf;
      uf = (mm[2] != 0) && (l > int'(me[2]));
      chk("out_uflow", out_uflow, uf);
      chk("out_exp", out_exp, (mm[2] == 0 || uf) ? 0 : int'(me[2]) - l);
    end
`endif
  endtask
  task automatic clear_model();
    foreach (mv[i]) mv[i] = 0;
  endtask
  task automatic cyc(input logic v, input logic [31:0] m, input logic r, input logic f,
                     input logic [7:0] e, output logic acc);
    logic adv, rdy;
    in_valid = v; in_mant = m; out_ready = r; flush = f;
`ifdef FPADDSUB_NORM_EXP_EN
    in_exp = e;
`endif
    #1;
    adv = !mv[2] || r;
    rdy = adv && !f;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mv[2]);
    if (mv[2]) check_out();
    acc = v && rdy;
    @(posedge clk);
    if (f) clear_model();
    else if (adv) begin
      mv[2] = mv[1]; mm[2] = mm[1]; me[2] = me[1];
      mv[1] = mv[0]; mm[1] = mm[0]; me[1] = me[0];
      mv[0] = acc; mm[0] = m; me[0] = e;
    end
    #1;
  endtask
  task automatic idle(input int n);
    logic a;
    repeat (n) cyc(0, 0, 1, 0, 0, a);
  endtask
  task automatic send(input logic [31:0] m, input logic [7:0] e);
    logic a;
    cyc(1, m, 1, 0, e, a);
  endtask
  task automatic check_reset();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_mant", out_mant, 0);
    chk("rst out_shift", out_shift, 0);
    chk("rst out_zero", out_zero, 0);
  endtask
  initial begin
    logic a;
    int idx;
    clear_model();
    rst_n = 1; flush = 0; in_valid = 0; in_mant = 0; out_ready = 1;
`ifdef FPADDSUB_NORM_EXP_EN
    in_exp = 0;
`endif
    #1 rst_n = 0;
    #1 check_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send(32'h0000_0001, 8'd40);
    idle(4);
    send(32'h8000_0000, 8'd3);
    send(32'h0000_0000, 8'd9);
    idle(4);
    words = '{32'h0000_1234, 32'h4000_0000, 32'h0000_0000, 32'h0FFF_FFFF};
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(idx < 4, idx < 4 ? words[idx] : 32'h0, (c >= 3 && c < 8) ? 1'b0 : 1'b1, 0, 8'(c + 10), a);
      if (a) idx++;
    end
    chk("stream accepted", idx, 4);
    send(32'h0000_00FF, 8'd1);
    send(32'h0001_0000, 8'd2);
    send(32'h0300_0000, 8'd3);
    cyc(1, 32'h1234_5678, 1, 1, 8'd4, a);
    send(32'h00F0_0000, 8'd30);
    idle(4);
    send(32'h0000_0010, 8'd7);
    send(32'h0000_0020, 8'd7);
    send(32'h0000_0040, 8'd7);
    rst_n = 0;
    #1 check_reset();
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(3);
    send(32'h0000_0800, 8'd50);
    idle(4);
`ifdef FPADDSUB_NORM_EXP_EN
    send(32'h0001_0000, 8'd5);
    send(32'h0001_0000, 8'd20);
    idle(4);
`endif
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 3) != 0, $urandom >> $urandom_range(0, 32),
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)), a);
    end
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpaddsub_normalize_pipe.md
FPADDSUB_NORMALIZE_PIPE -- requirements
Module: fpaddsub_normalize_pipe

Interface
REQ-001 Parameter WIDTH, default 32, is the mantissa width in bits; legal range 4..64.
REQ-002 Parameter EXP_W, default 8, is the exponent width; used only when FPADDSUB_NORM_EXP_EN is defined.
REQ-003 Derived localparam SHIFT_W = clog2(WIDTH+1) is the shift-count width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  input word valid.
REQ-008 in_ready  output  1  block accepts the input word this cycle.
REQ-009 in_mant  input  WIDTH  unnormalized mantissa.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_ready  input  1  downstream accepts the output word.
REQ-012 out_mant  output  WIDTH  normalized mantissa, MSB set unless out_zero.
REQ-013 out_shift  output  SHIFT_W  left-shift amount applied (leading-zero count).
REQ-014 out_zero  output  1  input mantissa was all zeros.

Function
REQ-015 Pipeline: S1 registers in_mant plus its leading-zero count; S2 left-shifts by 4*lzc[SHIFT_W-1:2], zero-filled; S3 left-shifts by lzc[1:0], zero-filled, and drives the outputs.
REQ-016 Shifts are logical left shifts, never rotations; vacated LSBs are 0.
REQ-017 Latency: exactly 3 clk edges from acceptance (in_valid & in_ready) to out_valid, with no stall.
REQ-018 Global advance = !out_valid | out_ready; all stages load only on advance; in_ready = advance.
REQ-019 Bubbles are not collapsed; a stage with valid=0 advances as an empty slot.
REQ-020 While out_valid=1 and out_ready=0, out_mant, out_shift, out_zero and out_valid hold stable.
REQ-021 in_mant = 0: out_zero=1, out_shift=WIDTH, out_mant=0.
REQ-022 in_mant MSB = 1: out_shift=0, out_mant=in_mant, out_zero=0.
REQ-023 flush=1 clears all stage valid bits on the next edge regardless of out_ready; any word presented that cycle is dropped; in_ready is forced 0 while flush=1.
REQ-024 Data registers need no reset; only valid bits are reset and flushed.
REQ-025 Throughput: one word per cycle while out_ready=1.

Reset
REQ-026 rst_n low asynchronously clears all stage valid bits; out_valid=0 immediately.
REQ-027 During reset, in_ready=0; out_mant, out_shift, out_zero read 0.
REQ-028 Release is synchronous to clk; first acceptance possible on the first edge with rst_n high.
REQ-029 Words in flight when reset asserts are discarded, never emitted.

Configuration
REQ-030 Macro FPADDSUB_NORM_EXP_EN defined: add ports in_exp (input, EXP_W), out_exp (output, EXP_W) and out_uflow (output, 1), carried through the pipeline alongside the mantissa.
REQ-031 With the macro: out_exp = in_exp - out_shift; if out_shift > in_exp, out_exp = 0 and out_uflow = 1, else out_uflow = 0; for zero input, out_exp = 0 and out_uflow = 0.
REQ-032 Without the macro: in_exp, out_exp and out_uflow are absent, and the remaining behaviour is identical.

Verification (WIDTH=32)
REQ-033 in_mant=0x00000001, out_ready=1 -> 3 cycles later out_mant=0x80000000, out_shift=31, out_zero=0.
REQ-034 in_mant=0x80000000 then 0x00000000 back-to-back -> shift 0, mant unchanged, then out_zero=1, out_shift=32, out_mant=0 on consecutive cycles.
REQ-035 Four words streamed, out_ready=0 for 5 cycles -> in_ready low while stalled; all four emitted in order with no loss or duplication; outputs stable while stalled.
REQ-036 Three words in flight, flush=1 for one cycle -> no out_valid for those words; next accepted word 0x00F00000 emerges with out_shift=8.
REQ-037 rst_n low mid-stream for 2 cycles -> out_valid=0 immediately; no stale word after release.
REQ-038 FPADDSUB_NORM_EXP_EN defined, in_exp=5, in_mant=0x00010000 -> out_shift=15, out_exp=0, out_uflow=1; in_exp=20, same mantissa -> out_exp=5, out_uflow=0.
